// File: rtl/cascade_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : cascade_pkg                                                      |
// | Shared constants, fixed-point type, FSM encoding and saturating adder for |
// | the Haar cascade stage controller.                                        |
// | Revision: 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package cascade_pkg;

    localparam int NUM_STAGES = 22;
    localparam int ACC_W      = 32;
    localparam int FRAC_W     = 16;
    localparam int IDX_W      = 5;

    typedef logic signed [ACC_W-1:0] fx_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } cascade_state_e;

    // One guard bit exposes overflow; clamp to the most positive/negative value.
    function automatic fx_t sat_add(input fx_t a, input fx_t b);
        logic signed [ACC_W:0] w_sum;
        fx_t                   w_res;
        w_sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
            w_res = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            w_res = w_sum[ACC_W-1:0];
        end
        return w_res;
    endfunction

endpackage : cascade_pkg
`default_nettype wire

// File: rtl/stage_cascade_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stage_cascade_ctrl                                               |
// | Walks cascade stages per window, accumulates signed votes and compares    |
// | each stage sum with its threshold; reports early reject or face.          |
// | Revision: 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
import cascade_pkg::*;

module stage_cascade_ctrl (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    win_valid,
    output logic                    win_ready,
    output logic [IDX_W-1:0]        thr_stage_idx,
    input  logic signed [ACC_W-1:0] thr_value,
    input  logic                    wc_valid,
    output logic                    wc_ready,
    input  logic signed [ACC_W-1:0] wc_vote,
    input  logic                    wc_last,
    output logic                    wc_flush,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    res_face,
    output logic [IDX_W-1:0]        res_stage
);

    localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0] c_pass_stage = IDX_W'(NUM_STAGES);

    cascade_state_e   r_state;
    fx_t              r_acc;
    logic [IDX_W-1:0] r_idx;
    logic             r_res_face;
    logic [IDX_W-1:0] r_res_stage;

    cascade_state_e   w_state_next;
    fx_t              w_acc_next;
    logic [IDX_W-1:0] w_idx_next;
    logic             w_face_next;
    logic [IDX_W-1:0] w_stage_next;
    logic             w_pass;
    logic             w_flush;

    // Equality passes: a stage sum exactly at threshold keeps the window alive.
    assign w_pass = (r_acc >= thr_value);

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_idx_next   = r_idx;
        w_face_next  = r_res_face;
        w_stage_next = r_res_stage;
        w_flush      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (win_valid) begin
                    w_acc_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (wc_valid) begin
                    w_acc_next = sat_add(r_acc, wc_vote);
                    if (wc_last) begin
                        w_state_next = ST_COMPARE;
                    end
                end
            end
            ST_COMPARE: begin
                if (w_pass) begin
                    if (r_idx == c_last_idx) begin
                        w_face_next  = 1'b1;
                        w_stage_next = c_pass_stage;
                        w_state_next = ST_DONE;
                    end else begin
                        w_idx_next   = r_idx + IDX_W'(1);
                        w_acc_next   = '0;
                        w_state_next = ST_ACCUM;
                    end
                end else begin
                    w_face_next  = 1'b0;
                    w_stage_next = r_idx;
                    w_flush      = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_idx       <= '0;
            r_res_face  <= 1'b0;
            r_res_stage <= '0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_idx       <= w_idx_next;
            r_res_face  <= w_face_next;
            r_res_stage <= w_stage_next;
        end
    end

    assign win_ready     = (r_state == ST_IDLE);
    assign wc_ready      = (r_state == ST_ACCUM);
    assign res_valid     = (r_state == ST_DONE);
    assign wc_flush      = w_flush;
    assign thr_stage_idx = r_idx;
    assign res_face      = r_res_face;
    assign res_stage     = r_res_stage;

endmodule : stage_cascade_ctrl
`default_nettype wire

// File: tb/tb_stage_cascade_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_stage_cascade_ctrl                                            |
// | Randomized and directed windows against a queue-based cascade model.      |
// | Revision: 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_stage_cascade_ctrl;
    import cascade_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              win_valid, win_ready;
    logic [4:0]        thr_stage_idx;
    logic signed [31:0] thr_value;
    logic              wc_valid, wc_ready, wc_last, wc_flush;
    logic signed [31:0] wc_vote;
    logic              res_valid, res_ready, res_face;
    logic [4:0]        res_stage;

    always #5 clk = ~clk;

    logic signed [31:0] thr_tab [0:31];
    assign thr_value = thr_tab[thr_stage_idx];

    stage_cascade_ctrl u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .win_valid     (win_valid),
        .win_ready     (win_ready),
        .thr_stage_idx (thr_stage_idx),
        .thr_value     (thr_value),
        .wc_valid      (wc_valid),
        .wc_ready      (wc_ready),
        .wc_vote       (wc_vote),
        .wc_last       (wc_last),
        .wc_flush      (wc_flush),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_face      (res_face),
        .res_stage     (res_stage)
    );

    typedef struct {
        bit face;
        int stage;
        bit hold;
    } exp_t;

    exp_t expq[$];
    int   nchecks = 0;
    int   nerr    = 0;
    int   flush_cnt = 0;

    logic signed [31:0] pv   [0:21][0:3];
    int                 pn   [0:21];
    logic signed [31:0] pthr [0:21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nchecks++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer sum clamped to the signed 32-bit range.
    function automatic longint clamp(input longint x);
        if (x > 64'sd2147483647)  return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    function automatic longint stage_sum(input int s);
        longint a = 0;
        for (int k = 0; k < pn[s]; k++) a = clamp(a + longint'(pv[s][k]));
        return a;
    endfunction

    function automatic exp_t model(input bit hold);
        exp_t e;
        e.hold  = hold;
        e.face  = 1'b1;
        e.stage = NUM_STAGES;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (stage_sum(s) < longint'(pthr[s])) begin
                e.face  = 1'b0;
                e.stage = s;
                return e;
            end
        end
        return e;
    endfunction

    task automatic build_random();
        for (int s = 0; s < NUM_STAGES; s++) begin
            pn[s]   = int'($urandom_range(1, 4));
            pthr[s] = 32'($urandom_range(0, 32'h30000)) - 32'h18000;
            for (int k = 0; k < 4; k++)
                pv[s][k] = 32'($urandom_range(0, 32'h30000)) - 32'h10000;
        end
    endtask

    task automatic load_thr();
        for (int s = 0; s < NUM_STAGES; s++) thr_tab[s] = pthr[s];
    endtask

    task automatic start_window();
        int t = 0;
        @(negedge clk);
        win_valid = 1'b1;
        while (!win_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("win_ready_timeout", {31'b0, win_ready}, 32'd1);
        @(posedge clk);
        #1;
        win_valid = 1'b0;
        chk("start_idx", {27'b0, thr_stage_idx}, 32'd0);
        chk("start_wc_ready", {31'b0, wc_ready}, 32'd1);
    endtask

    task automatic send_vote(input logic [31:0] v, input bit last, input int s);
        int t = 0;
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        wc_valid = 1'b1;
        wc_vote  = v;
        wc_last  = last;
        while (!wc_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("vote_ready_timeout", {31'b0, wc_ready}, 32'd1);
        chk("thr_stage_idx", {27'b0, thr_stage_idx}, 32'(s));
        @(posedge clk);
        #1;
        wc_valid = 1'b0;
        wc_last  = 1'b0;
    endtask

    // mode: 0 random, 1 pass at 0xD29C, 2 reject at stage 0, 3 all-equal pass, 4 saturation
    task automatic run_window(input int mode, input bit hold);
        exp_t e;
        int   last_s;
        bit   pass_s;
        build_random();
        case (mode)
            1: begin
                pn[0] = 2; pv[0][0] = 32'h8000; pv[0][1] = 32'h6000; pthr[0] = 32'hD29C;
            end
            2: begin
                pn[0] = 2; pv[0][0] = 32'h4000; pv[0][1] = 32'h4000; pthr[0] = 32'hD29C;
            end
            3: begin
                pn[1] = 2; pv[1][0] = 32'h0007_0000; pv[1][1] = 32'hFFFF_F4D4;
                pn[5] = 1;
                for (int s = 0; s < NUM_STAGES; s++) pthr[s] = 32'(stage_sum(s));
            end
            4: begin
                pn[0] = 3; pthr[0] = 32'h7FFF_FFFF;
                for (int k = 0; k < 3; k++) pv[0][k] = 32'h7FFF_0000;
                pn[1] = 3; pthr[1] = 32'h8000_0001;
                for (int k = 0; k < 3; k++) pv[1][k] = 32'h8001_0000;
            end
            default: ;
        endcase
        e = model(hold);
        expq.push_back(e);
        load_thr();
        start_window();
        last_s = e.face ? NUM_STAGES - 1 : e.stage;
        for (int s = 0; s <= last_s; s++) begin
            for (int k = 0; k < pn[s]; k++) send_vote(pv[s][k], k == pn[s] - 1, s);
            chk("cmp_wc_ready", {31'b0, wc_ready}, 32'd0);
            if (mode == 0) begin
                wc_valid = 1'b1;
                wc_vote  = 32'($urandom());
                wc_last  = 1'b1;
            end
            @(posedge clk);
            #1;
            wc_valid = 1'b0;
            wc_last  = 1'b0;
            pass_s = e.face || (s != e.stage);
            if (pass_s && s < NUM_STAGES - 1) begin
                chk("next_idx", {27'b0, thr_stage_idx}, 32'(s + 1));
                chk("next_wc_ready", {31'b0, wc_ready}, 32'd1);
            end else begin
                chk("res_latency", {31'b0, res_valid}, 32'd1);
            end
        end
    endtask

    task automatic reset_window();
        build_random();
        pn[0] = 4;
        load_thr();
        start_window();
        for (int k = 0; k < 3; k++) send_vote(pv[0][k], 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_win_ready", {31'b0, win_ready}, 32'd1);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_wc_ready", {31'b0, wc_ready}, 32'd0);
        chk("rst_wc_flush", {31'b0, wc_flush}, 32'd0);
        rst_n = 1'b1;
    endtask

    // Result monitor: random backpressure, stability and scoreboard compare.
    bit         hs = 1'b0;
    bit         seen = 1'b0;
    int         wcnt = 0;
    logic       f0;
    logic [4:0] st0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            res_ready = 1'b0;
            hs        = 1'b0;
            seen      = 1'b0;
            flush_cnt = 0;
        end else begin
            if (wc_flush) flush_cnt++;
            if (hs) begin
                chk("idle_after_res", {30'b0, res_valid, win_ready}, 32'd1);
                hs = 1'b0;
            end
            if (res_valid) begin
                chk("wc_ready_in_done", {31'b0, wc_ready}, 32'd0);
                if (!seen) begin
                    seen = 1'b1;
                    f0   = res_face;
                    st0  = res_stage;
                    wcnt = (expq.size() > 0 && expq[0].hold) ? 5 : int'($urandom_range(0, 3));
                end else begin
                    chk("res_stable", {26'b0, res_face, res_stage}, {26'b0, f0, st0});
                end
                if (wcnt == 0) begin
                    if (expq.size() == 0) begin
                        nchecks++;
                        nerr++;
                        $display("FAIL unexpected_result: actual face=%0d stage=%0d required none",
                                 res_face, res_stage);
                    end else begin
                        e = expq.pop_front();
                        chk("res_face", {31'b0, res_face}, {31'b0, e.face});
                        chk("res_stage", {27'b0, res_stage}, 32'(e.stage));
                        chk("flush_count", 32'(flush_cnt), e.face ? 32'd0 : 32'd1);
                    end
                    flush_cnt = 0;
                    res_ready = 1'b1;
                    hs        = 1'b1;
                    seen      = 1'b0;
                end else begin
                    wcnt--;
                    res_ready = 1'b0;
                end
            end else begin
                res_ready = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        for (int i = 0; i < 32; i++) thr_tab[i] = '0;
        rst_n     = 1'b0;
        win_valid = 1'b0;
        wc_valid  = 1'b0;
        wc_vote   = '0;
        wc_last   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_win_ready", {31'b0, win_ready}, 32'd1);
        chk("reset_wc_ready", {31'b0, wc_ready}, 32'd0);
        chk("reset_wc_flush", {31'b0, wc_flush}, 32'd0);
        chk("reset_res_valid", {31'b0, res_valid}, 32'd0);
        chk("reset_res_face", {31'b0, res_face}, 32'd0);
        chk("reset_res_stage", {27'b0, res_stage}, 32'd0);
        chk("reset_idx", {27'b0, thr_stage_idx}, 32'd0);
        rst_n = 1'b1;

        run_window(1, 1'b0);
        run_window(2, 1'b0);
        run_window(3, 1'b1);
        run_window(4, 1'b0);
        reset_window();
        for (int w = 0; w < 40; w++) run_window(0, w % 7 == 3);
        run_window(3, 1'b0);
        run_window(2, 1'b1);

        t = 0;
        while (expq.size() > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_results", 32'(expq.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule : tb_stage_cascade_ctrl
`default_nettype wire
